// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Generic pipeline stage register for any stage boundary (IF/ID, ID/EX,
//   EX/MEM, MEM/WB). It carries one instruction word and its PC behind a
//   valid/ready handshake. A 2-entry skid buffer (main + skid) lets a
//   downstream stall reach upstream one cycle late without dropping data.
//   A hazard-unit write gate blocks acceptance, and a branch flush empties
//   the stage and presents a bubble.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   reset      : synchronous, active-low reset
//   in_valid   : upstream presents a valid instr/pc
//   in_ready   : stage accepts this cycle (no combinational path from out_ready)
//   in_instr   : incoming instruction word (DATA_W)
//   in_pc      : incoming PC (PC_W)
//   hzd_write  : hazard-unit write enable, 0 blocks acceptance only
//   flush      : drop all contents and present a bubble
//   out_valid  : out_instr/out_pc are valid
//   out_ready  : downstream accepts this cycle
//   out_instr  : registered instruction (NOP_VALUE after reset/flush)
//   out_pc     : registered PC (0 after reset/flush)
//
// Optional build macro PIPE_STAGE_STATS_EN adds saturating 16-bit counters:
//   stall_cnt  : cycles with in_valid && !in_ready while out of reset
//   bubble_cnt : cycles with !out_valid && out_ready
//   flush_cnt  : cycles with flush=1
module pipe_stage_reg #(
  parameter int                 DATA_W    = 32,
  parameter int                 PC_W      = 32,
  parameter logic [DATA_W-1:0]  NOP_VALUE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              hzd_write,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [PC_W-1:0]   out_pc
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       bubble_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_main_instr_p1;
  logic [PC_W-1:0]     r_main_pc_p1;
  logic [DATA_W-1:0]   r_skid_instr_p1;
  logic [PC_W-1:0]     r_skid_pc_p1;

  logic                w_acc;
  logic                w_drn;

  // Ready depends only on registered state and the three gating inputs, so
  // a downstream stall never ripples combinationally to upstream.
  assign in_ready  = reset && hzd_write && !flush && (r_state != S_FULL);
  assign out_valid = (r_state != S_EMPTY);
  assign out_instr = r_main_instr_p1;
  assign out_pc    = r_main_pc_p1;

  assign w_acc = in_valid && in_ready;
  assign w_drn = out_valid && out_ready;

  // ---- stage boundary: upstream -> main/skid registers ----
  // Skid payload is only loaded on an accept in ONE and needs no reset:
  // it is never observed unless the state says it is valid.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      r_state         <= S_EMPTY;
      r_main_instr_p1 <= NOP_VALUE;
      r_main_pc_p1    <= '0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_acc) begin
            r_state         <= S_ONE;
            r_main_instr_p1 <= in_instr;
            r_main_pc_p1    <= in_pc;
          end
        end
        S_ONE: begin
          if (w_acc && w_drn) begin
            r_main_instr_p1 <= in_instr;
            r_main_pc_p1    <= in_pc;
          end else if (w_acc) begin
            r_state         <= S_FULL;
            r_skid_instr_p1 <= in_instr;
            r_skid_pc_p1    <= in_pc;
          end else if (w_drn) begin
            // Main data left as-is; it is don't-care while EMPTY.
            r_state <= S_EMPTY;
          end
        end
        S_FULL: begin
          // Skid always leaves after main, keeping FIFO order.
          if (w_drn) begin
            r_state         <= S_ONE;
            r_main_instr_p1 <= r_skid_instr_p1;
            r_main_pc_p1    <= r_skid_pc_p1;
          end
        end
        default: begin
          r_state <= S_EMPTY;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_bubble_cnt;
  logic [15:0] r_flush_cnt;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    if (en && (v != 16'hFFFF)) begin
      return v + 16'd1;
    end
    return v;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
      r_flush_cnt  <= '0;
    end else begin
      r_stall_cnt  <= sat_inc(r_stall_cnt, in_valid && !in_ready);
      r_bubble_cnt <= sat_inc(r_bubble_cnt, !out_valid && out_ready);
      r_flush_cnt  <= sat_inc(r_flush_cnt, flush);
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
  assign flush_cnt  = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  localparam int                DATA_W = 32;
  localparam int                PC_W   = 32;
  localparam logic [DATA_W-1:0] NOP    = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_instr;
  logic [PC_W-1:0]   in_pc;
  logic              hzd_write;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [PC_W-1:0]   out_pc;
`ifdef PIPE_STAGE_STATS_EN
  logic [15:0]       stall_cnt;
  logic [15:0]       bubble_cnt;
  logic [15:0]       flush_cnt;
`endif

  pipe_stage_reg #(
    .DATA_W   (DATA_W),
    .PC_W     (PC_W),
    .NOP_VALUE(NOP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_instr (in_instr),
    .in_pc    (in_pc),
    .hzd_write(hzd_write),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .out_pc   (out_pc)
`ifdef PIPE_STAGE_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the stage is a FIFO of depth 2 of {instr, pc}.
  // Expected entries are pushed on accept and popped when downstream takes them.
  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [PC_W-1:0]   pc;
  } item_t;

  item_t sbq[$];
  bit    known    = 0;
  bit    nop_flag = 0;
  int    m_stall  = 0;
  int    m_bubble = 0;
  int    m_flush  = 0;

  function automatic int sat(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  // Monitor: samples mid-cycle, when inputs and outputs are both stable.
  always @(negedge clk) begin
    bit    exp_rdy;
    bit    exp_vld;
    item_t it;
    exp_rdy = reset && hzd_write && !flush && (sbq.size() < 2);
    exp_vld = (sbq.size() > 0);
    if (known) begin
      chk("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
      chk("out_valid", {63'd0, out_valid}, {63'd0, exp_vld});
      if (exp_vld) begin
        chk("out_instr", {32'd0, out_instr}, {32'd0, sbq[0].instr});
        chk("out_pc", {32'd0, out_pc}, {32'd0, sbq[0].pc});
      end else if (nop_flag) begin
        chk("bubble_instr", {32'd0, out_instr}, {32'd0, NOP});
        chk("bubble_pc", {32'd0, out_pc}, 64'd0);
      end
`ifdef PIPE_STAGE_STATS_EN
      chk("stall_cnt", {48'd0, stall_cnt}, 64'(m_stall));
      chk("bubble_cnt", {48'd0, bubble_cnt}, 64'(m_bubble));
      chk("flush_cnt", {48'd0, flush_cnt}, 64'(m_flush));
`endif
    end
    // Advance the model across the coming rising edge.
    if (!reset) begin
      known    = 1;
      nop_flag = 1;
      sbq.delete();
      m_stall  = 0;
      m_bubble = 0;
      m_flush  = 0;
    end else if (known) begin
      if (in_valid && !exp_rdy) m_stall  = sat(m_stall);
      if (!exp_vld && out_ready) m_bubble = sat(m_bubble);
      if (flush)                 m_flush  = sat(m_flush);
      if (flush) begin
        sbq.delete();
        nop_flag = 1;
      end else begin
        if (exp_vld && out_ready) void'(sbq.pop_front());
        if (in_valid && exp_rdy) begin
          it.instr = in_instr;
          it.pc    = in_pc;
          sbq.push_back(it);
          nop_flag = 0;
        end
      end
    end
  end

  // Drive one cycle of inputs, then step past the next rising edge.
  task automatic drive(input bit rst, input bit v, input logic [31:0] ins,
                       input logic [31:0] pc, input bit hzd, input bit fl, input bit ordy);
    reset     = rst;
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    hzd_write = hzd;
    flush     = fl;
    out_ready = ordy;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) drive(1, 0, 32'hDEAD_BEEF, 32'hFFFF_FFF0, 1, 0, ordy);
  endtask

  initial begin
    reset = 0; in_valid = 0; in_instr = '0; in_pc = '0;
    hzd_write = 1; flush = 0; out_ready = 0;

    // Reset held with valid input present.
    drive(0, 1, 32'h1234_5678, 32'h40, 1, 0, 1);
    drive(0, 1, 32'h1234_5678, 32'h40, 1, 0, 1);
    drive(1, 1, 32'h2002_0005, 32'h0000_0004, 1, 0, 1);
    idle(2, 1);

    // Streaming 8 back-to-back words.
    for (int i = 0; i < 8; i++) drive(1, 1, 32'hA000_0000 + i, 32'(i * 4), 1, 0, 1);
    idle(2, 1);

    // Skid: A, B fill the stage, C waits until space appears.
    drive(1, 1, 32'h11, 32'h100, 1, 0, 0);
    drive(1, 1, 32'h22, 32'h104, 1, 0, 0);
    drive(1, 1, 32'h33, 32'h108, 1, 0, 0);
    drive(1, 1, 32'h33, 32'h108, 1, 0, 1);
    drive(1, 1, 32'h33, 32'h108, 1, 0, 1);
    idle(3, 1);

    // Hazard stall with main holding 0x44.
    drive(1, 1, 32'h44, 32'h200, 1, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, 1, 32'h99, 32'h204, 0, 0, 0);
    drive(1, 1, 32'h99, 32'h204, 1, 0, 0);
    idle(3, 1);

    // Flush while FULL, with a valid input in the same cycle.
    drive(1, 1, 32'h55, 32'h300, 1, 0, 0);
    drive(1, 1, 32'h66, 32'h304, 1, 0, 0);
    drive(1, 1, 32'h77, 32'h308, 1, 1, 0);
    idle(3, 1);

    // Flush coinciding with a drain and a full-throughput stream.
    drive(1, 1, 32'h88, 32'h400, 1, 0, 1);
    drive(1, 1, 32'h89, 32'h404, 1, 1, 1);
    idle(2, 1);

    // Randomized traffic including occasional reset and flush.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 99) != 0), $urandom_range(0, 3) != 0, $urandom, $urandom,
            $urandom_range(0, 4) != 0, $urandom_range(0, 24) == 0, $urandom_range(0, 2) != 0);
    end
    idle(3, 1);

`ifdef PIPE_STAGE_STATS_EN
    // Counters: 3 stalled cycles plus 1 flush after a fresh reset.
    drive(0, 0, 32'h0, 32'h0, 1, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, 1, 32'h5, 32'h8, 0, 0, 0);
    drive(1, 0, 32'h0, 32'h0, 1, 1, 0);
    @(negedge clk);
    chk("stall_cnt_dir", {48'd0, stall_cnt}, 64'd3);
    chk("flush_cnt_dir", {48'd0, flush_cnt}, 64'd1);
    for (int i = 0; i < 70000; i++) drive(1, 1, 32'h5, 32'h8, 0, 0, 0);
    @(negedge clk);
    chk("stall_cnt_sat", {48'd0, stall_cnt}, 64'hFFFF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
